snake_chain: RTL



---
 rtl/snake_pkg.sv | 19 +
 rtl/snake_path_decode.sv | 32 +++
 rtl/snake_chain.sv | 115 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the seven-segment snake animation.
// Segment bit positions within a digit, and the length of the perimeter path.
package snake_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic int path_len(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/snake_path_decode.sv
// Maps one perimeter path index onto an active-high one-hot segment vector
// covering the whole digit row.
module snake_path_decode
    import snake_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int IDX_W    = 3
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [7*N_DIGITS-1:0] hot
);

    always_comb begin
        hot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (int'(idx) == i)
                hot[7*i+SEG_A] = 1'b1;
            // bottom edge runs right-to-left: digit i sits at index 2N+1-i
            if (int'(idx) == 2 * N_DIGITS + 1 - i)
                hot[7*i+SEG_D] = 1'b1;
        end
        if (int'(idx) == N_DIGITS)
            hot[7*(N_DIGITS-1)+SEG_B] = 1'b1;
        if (int'(idx) == N_DIGITS + 1)
            hot[7*(N_DIGITS-1)+SEG_C] = 1'b1;
        if (int'(idx) == 2 * N_DIGITS + 2)
            hot[SEG_E] = 1'b1;
        if (int'(idx) == 2 * N_DIGITS + 3)
            hot[SEG_F] = 1'b1;
    end

endmodule

// File: rtl/snake_chain.sv
// Snake animation around the outer perimeter of a row of active-low
// seven-segment digits, with step-rate, reversal, pause and blanking control.
module snake_chain
    import snake_pkg::*;
#(
    parameter int N_DIGITS  = 2,
    parameter int SNAKE_LEN = 3,
    parameter int CNT_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  blank,
    input  logic [CNT_W-1:0]      step_ticks,
    output logic [7*N_DIGITS-1:0] seg_n,
    output logic                  step,
    output logic                  lap
);

    localparam int P     = path_len(N_DIGITS);
    localparam int IDX_W = $clog2(P);
    localparam int EW    = IDX_W + 1;
    localparam logic [EW-1:0]    P_E      = EW'(P);
    localparam logic [EW-1:0]    TAIL_OFS = EW'(SNAKE_LEN - 1);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(P - 1);
    localparam int SW = 7 * N_DIGITS;

    logic [IDX_W-1:0] head;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] eff_m1;
    logic             do_step;
    logic             reverse;
    logic [EW-1:0]    head_e;
    logic [EW-1:0]    tail_e;
    logic [IDX_W-1:0] head_nxt;
    logic             wrap_nxt;
    logic [SW-1:0]    hot [SNAKE_LEN];
    logic [SW-1:0]    lit;

    assign head_e = {1'b0, head};

    always_comb begin
        eff_m1   = (step_ticks == '0) ? '0 : step_ticks - 1'b1;
        do_step  = en && (cnt >= eff_m1);
        reverse  = (dir != dir_q);
        head_nxt = head;
        wrap_nxt = 1'b0;
        // reversing swaps head and tail so the lit set stays put on that step
        if (!dir_q) tail_e = head_e + P_E - TAIL_OFS;
        else        tail_e = head_e + TAIL_OFS;
        if (tail_e >= P_E) tail_e = tail_e - P_E;
        if (reverse) begin
            head_nxt = tail_e[IDX_W-1:0];
        end else if (!dir_q) begin
            wrap_nxt = (head == LAST);
            head_nxt = wrap_nxt ? '0 : head + 1'b1;
        end else begin
            wrap_nxt = (head == '0);
            head_nxt = wrap_nxt ? LAST : head - 1'b1;
        end
    end

    for (genvar k = 0; k < SNAKE_LEN; k++) begin : g_lit
        localparam logic [EW-1:0] K_E = EW'(k);
        logic [EW-1:0] pos_e;

        always_comb begin
            if (!dir_q) pos_e = head_e + P_E - K_E;
            else        pos_e = head_e + K_E;
            if (pos_e >= P_E) pos_e = pos_e - P_E;
        end

        snake_path_decode #(
            .N_DIGITS (N_DIGITS),
            .IDX_W    (IDX_W)
        ) u_dec (
            .idx (pos_e[IDX_W-1:0]),
            .hot (hot[k])
        );
    end

    always_comb begin
        lit = '0;
        for (int k = 0; k < SNAKE_LEN; k++)
            lit = lit | hot[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= IDX_W'(SNAKE_LEN - 1);
            dir_q <= 1'b0;
            cnt   <= '0;
            seg_n <= {N_DIGITS{SEG_OFF}};
            step  <= 1'b0;
            lap   <= 1'b0;
        end else begin
            seg_n <= blank ? {N_DIGITS{SEG_OFF}} : ~lit;
            step  <= do_step;
            lap   <= do_step && !reverse && wrap_nxt;
            if (en) begin
                if (do_step) begin
                    cnt   <= '0;
                    head  <= head_nxt;
                    dir_q <= dir;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
